// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared types and constants for the APU frame counter controller
//
// Purpose: state encoding of the load-delay FSM, register bit positions,
// CPU register addresses and a small helper used when (re)arming the delay.
// Optional feature macro used by the importing files: FC_RESET_LOAD_EN.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIRE
  } fc_state_t;

  localparam int FC_MODE_BIT    = 7;
  localparam int FC_INHIBIT_BIT = 6;

  localparam logic [15:0] FC_ADDR     = 16'h4017;
  localparam logic [15:0] STATUS_ADDR = 16'h4015;

  // A delay of 1 (or 0) has no intermediate strobe to wait for, so the
  // sequencer goes straight to FIRE and loads on the very next CPU strobe.
  function automatic fc_state_t fc_arm_state(input int unsigned delay);
    return (delay <= 1) ? FIRE : WAIT;
  endfunction

endpackage

// File: rtl/frame_counter_ctrl_if.sv
// rtl/frame_counter_ctrl_if.sv - CPU/frame-counter side signals of frame_counter_ctrl
//
// Purpose: bundles the register-side inputs and the frame-counter-side outputs.
// Ports (signals):
//   cpu_clk_en        one-clk strobe per CPU cycle
//   reg_we            one-clk pulse, CPU write to $4017
//   reg_wdata[7:0]    write data, bit7 = mode, bit6 = IRQ inhibit
//   status_rd         one-clk pulse, CPU read of $4015 (clears flag)
//   fc_interrupt      interrupt level from the frame counter
//   mode              sequencer mode (0 = 4-step, 1 = 5-step)
//   inhibit_interrupt IRQ inhibit to the frame counter
//   load              one-clk reset/load strobe to the frame counter
//   frame_irq         sticky frame IRQ flag
//   busy              a delayed load is pending
// Modports: master drives the inputs (CPU/bench side), slave is the controller.
interface frame_counter_ctrl_if;

  logic       cpu_clk_en;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic       status_rd;
  logic       fc_interrupt;
  logic       mode;
  logic       inhibit_interrupt;
  logic       load;
  logic       frame_irq;
  logic       busy;

  modport master (
    output cpu_clk_en, reg_we, reg_wdata, status_rd, fc_interrupt,
    input  mode, inhibit_interrupt, load, frame_irq, busy
  );

  modport slave (
    input  cpu_clk_en, reg_we, reg_wdata, status_rd, fc_interrupt,
    output mode, inhibit_interrupt, load, frame_irq, busy
  );

endinterface

// File: rtl/fc_load_delay.sv
// rtl/fc_load_delay.sv - parity-dependent write delay ahead of the frame counter load strobe
//
// Purpose: tracks CPU-cycle parity and counts DELAY_EVEN / DELAY_ODD CPU
// strobes after a start pulse, then emits a single load strobe aligned with
// a CPU strobe. A new start while pending restarts the countdown.
// Optional macro FC_RESET_LOAD_EN: arm one load automatically after reset.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   cpu_clk_en   one-clk strobe per CPU cycle
//   start        one-clk pulse, register write accepted
//   load         one-clk load strobe (FIRE and cpu_clk_en)
//   busy         state is not IDLE
module fc_load_delay
  import apu_pkg::*;
#(
  parameter int DELAY_EVEN = 3,
  parameter int DELAY_ODD  = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_clk_en,
  input  logic start,
  output logic load,
  output logic busy
);

  fc_state_t        state;
  logic             parity;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] start_cnt;

  // Parity is the value held during the write clk, before this clk's toggle.
  assign start_cnt = parity ? CNT_W'(DELAY_ODD) : CNT_W'(DELAY_EVEN);

  assign load = (state == FIRE) && cpu_clk_en;
  assign busy = (state != IDLE);

`ifdef FC_RESET_LOAD_EN
  logic boot;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      parity <= 1'b0;
      cnt    <= '0;
`ifdef FC_RESET_LOAD_EN
      boot   <= 1'b1;
`endif
    end else begin
      if (cpu_clk_en) parity <= ~parity;
`ifdef FC_RESET_LOAD_EN
      boot <= 1'b0;
`endif
      if (start) begin
        // Last write wins; also covers a write in the clk where load fires.
        cnt   <= start_cnt;
        state <= fc_arm_state(int'(start_cnt));
      end
`ifdef FC_RESET_LOAD_EN
      else if (boot) begin
        cnt   <= CNT_W'(DELAY_EVEN);
        state <= fc_arm_state(DELAY_EVEN);
      end
`endif
      else begin
        case (state)
          WAIT: begin
            if (cpu_clk_en) begin
              if (cnt > CNT_W'(1)) cnt <= cnt - CNT_W'(1);
              // Entering FIRE as the count reaches 1 puts load on the next
              // strobe, i.e. the Nth strobe after the write.
              if (cnt <= CNT_W'(2)) state <= FIRE;
            end
          end
          FIRE: begin
            if (cpu_clk_en) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/frame_counter_ctrl.sv
// rtl/frame_counter_ctrl.sv - register-side controller for the APU frame counter
//
// Purpose: decodes $4017 writes (mode applied at the delayed load, IRQ
// inhibit applied at once), drives the delayed load strobe and owns the
// sticky frame IRQ flag cleared by $4015 reads.
// Optional macro FC_RESET_LOAD_EN (in fc_load_delay): power-up load after reset.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   frame_counter_ctrl_if.slave (see interface for signal list)
module frame_counter_ctrl
  import apu_pkg::*;
#(
  parameter int DELAY_EVEN = 3,
  parameter int DELAY_ODD  = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_counter_ctrl_if.slave   bus
);

  logic pend_mode;
  logic load_i;
  logic busy_i;
  logic irq_set;
  logic irq_clr;
  logic unused_wdata;

  assign unused_wdata = ^bus.reg_wdata[5:0];

  fc_load_delay #(
    .DELAY_EVEN (DELAY_EVEN),
    .DELAY_ODD  (DELAY_ODD),
    .CNT_W      (CNT_W)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .cpu_clk_en (bus.cpu_clk_en),
    .start      (bus.reg_we),
    .load       (load_i),
    .busy       (busy_i)
  );

  assign bus.load = load_i;
  assign bus.busy = busy_i;

  assign irq_set = bus.fc_interrupt & bus.cpu_clk_en & ~bus.inhibit_interrupt;
  assign irq_clr = bus.status_rd | (bus.reg_we & bus.reg_wdata[FC_INHIBIT_BIT]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_mode             <= 1'b0;
      bus.mode              <= 1'b0;
      bus.inhibit_interrupt <= 1'b0;
      bus.frame_irq         <= 1'b0;
    end else begin
      if (bus.reg_we) begin
        pend_mode             <= bus.reg_wdata[FC_MODE_BIT];
        bus.inhibit_interrupt <= bus.reg_wdata[FC_INHIBIT_BIT];
      end
      // Old pend_mode is used if a write lands in the same clk as load.
      if (load_i) bus.mode <= pend_mode;
      if (irq_set)      bus.frame_irq <= 1'b1;
      else if (irq_clr) bus.frame_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_counter_ctrl.sv
// tb/tb_frame_counter_ctrl.sv - self-checking bench for frame_counter_ctrl
module tb_frame_counter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frame_counter_ctrl_if bus ();

  frame_counter_ctrl #(
    .DELAY_EVEN (3),
    .DELAY_ODD  (4),
    .CNT_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   s;
    logic m;
  } exp_t;

  exp_t q[$];
  int   tests      = 0;
  int   fails      = 0;
  int   strobe_cnt = 0;
  logic mode_chk   = 1'b0;
  logic exp_mode   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk of stimulus, driven at the falling edge. Also updates the model:
  // a write schedules a load N strobes later and replaces a pending one.
  task automatic step(input logic en, input logic we = 1'b0, input logic [7:0] wd = 8'h00,
                      input logic rd = 1'b0, input logic intr = 1'b0);
    int   par;
    logic firing;
    exp_t e;
    @(negedge clk);
    bus.cpu_clk_en   = en;
    bus.reg_we       = we;
    bus.reg_wdata    = wd;
    bus.status_rd    = rd;
    bus.fc_interrupt = intr;
    par = strobe_cnt % 2;
    if (en) strobe_cnt++;
    if (we) begin
      firing = (q.size() > 0) && en && (q[0].s == strobe_cnt);
      if (!firing) q.delete();
      e.s = strobe_cnt + ((par == 1) ? 4 : 3);
      e.m = wd[7];
      q.push_back(e);
    end
  endtask

  task automatic cpu(input int n);
    repeat (n) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mode"},    {31'd0, bus.mode},              32'd0);
    check({tag, "_inhibit"}, {31'd0, bus.inhibit_interrupt}, 32'd0);
    check({tag, "_load"},    {31'd0, bus.load},              32'd0);
    check({tag, "_irq"},     {31'd0, bus.frame_irq},         32'd0);
    check({tag, "_busy"},    {31'd0, bus.busy},              32'd0);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    mode_chk = 1'b0;
    step(1'b1);
    step(1'b0);
    check_all_zero(tag);
    @(negedge clk);
    rst              = 1'b0;
    bus.cpu_clk_en   = 1'b0;
    bus.reg_we       = 1'b0;
    bus.reg_wdata    = 8'h00;
    bus.status_rd    = 1'b0;
    bus.fc_interrupt = 1'b0;
    strobe_cnt       = 0;
`ifdef FC_RESET_LOAD_EN
    e.s = 3;
    e.m = 1'b0;
    q.push_back(e);
`endif
  endtask

  // Load monitor: every load must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mode_chk) begin
      check("mode_after_load", {31'd0, bus.mode}, {31'd0, exp_mode});
      mode_chk = 1'b0;
    end
    if (!rst && bus.load) begin
      if (q.size() == 0) begin
        check("unexpected_load", {31'd0, bus.load}, 32'd0);
      end else begin
        e = q.pop_front();
        check("load_strobe", strobe_cnt, e.s);
        exp_mode = e.m;
        mode_chk = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_clk_en   = 1'b0;
    bus.reg_we       = 1'b0;
    bus.reg_wdata    = 8'h00;
    bus.status_rd    = 1'b0;
    bus.fc_interrupt = 1'b0;

    do_reset("reset");
`ifdef FC_RESET_LOAD_EN
    cpu(4);
`endif

    // Even-cycle write, 5-step mode
    step(1'b0, 1'b1, 8'h80);
    step(1'b0);
    check("even_busy_start", {31'd0, bus.busy}, 32'd1);
    check("even_mode_held", {31'd0, bus.mode}, 32'd0);
    cpu(2);
    check("even_busy_mid", {31'd0, bus.busy}, 32'd1);
    cpu(1);
    check("even_busy_end", {31'd0, bus.busy}, 32'd0);
    check("even_mode", {31'd0, bus.mode}, 32'd1);

    // Odd-cycle write, 4-step mode
    step(1'b0, 1'b1, 8'h00);
    cpu(3);
    check("odd_busy_mid", {31'd0, bus.busy}, 32'd1);
    cpu(1);
    check("odd_busy_end", {31'd0, bus.busy}, 32'd0);
    check("odd_mode", {31'd0, bus.mode}, 32'd0);

    // Back-to-back writes: second (on a strobe clk) wins, one load
    step(1'b0, 1'b1, 8'h80);
    cpu(2);
    step(1'b1, 1'b1, 8'h00);
    step(1'b0);
    step(1'b0);
    cpu(5);
    check("b2b_busy_end", {31'd0, bus.busy}, 32'd0);
    check("b2b_mode", {31'd0, bus.mode}, 32'd0);

    // IRQ flag set / clear / priority
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0);
    check("irq_set", {31'd0, bus.frame_irq}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0);
    check("irq_clear_rd", {31'd0, bus.frame_irq}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0);
    check("irq_set_wins", {31'd0, bus.frame_irq}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0);
    check("irq_needs_strobe", {31'd0, bus.frame_irq}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0);
    check("irq_reset_again", {31'd0, bus.frame_irq}, 32'd1);

    // Inhibit write clears flag immediately and blocks later sets
    step(1'b0, 1'b1, 8'h40);
    step(1'b0);
    check("inh_irq_cleared", {31'd0, bus.frame_irq}, 32'd0);
    check("inh_applied", {31'd0, bus.inhibit_interrupt}, 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0);
    check("inh_blocks_set", {31'd0, bus.frame_irq}, 32'd0);
    step(1'b0);
    cpu(3);
    check("inh_mode", {31'd0, bus.mode}, 32'd0);

    // Reset one CPU cycle into WAIT: pending load discarded
    step(1'b0, 1'b1, 8'h00);
    cpu(1);
    check("rstwait_busy", {31'd0, bus.busy}, 32'd1);
    do_reset("rst_mid_wait");
    cpu(6);
    check("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    check("pending_loads", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
